// File: rtl/control_pantalla_pkg.sv
// Shared definitions for the display-mode controller: state encoding,
// cam_co field bases and the default frame-boundary line.
package control_pantalla_pkg;

  typedef enum logic [2:0] {
    NORMAL     = 3'd0,
    EDIT_HORA  = 3'd1,
    EDIT_FECHA = 3'd2,
    EDIT_CRONO = 3'd3,
    ALARMA     = 3'd4
  } state_t;

  localparam logic [3:0] BASE_HORA  = 4'd8;
  localparam logic [3:0] BASE_FECHA = 4'd5;
  localparam logic [3:0] BASE_CRONO = 4'd2;

  localparam logic [9:0] FRAME_LINE_DEF = 10'd515;

  function automatic logic is_edit(input state_t s);
    return (s == EDIT_HORA) || (s == EDIT_FECHA) || (s == EDIT_CRONO);
  endfunction

  // One-hot highlight for the field under the cursor; zero outside edit modes.
  function automatic logic [8:0] field_mask(input state_t s, input logic [1:0] cur);
    logic [3:0] base;
    base = BASE_HORA;
    case (s)
      EDIT_FECHA: base = BASE_FECHA;
      EDIT_CRONO: base = BASE_CRONO;
      default:    base = BASE_HORA;
    endcase
    if (!is_edit(s)) begin
      return '0;
    end
    return 9'd1 << (base - {2'b00, cur});
  endfunction

endpackage

// File: rtl/control_pantalla_frame_sync.sv
// Frame-boundary detector: one reloj-cycle pulse when the VGA counters first
// reach (FRAME_LINE, 0), regardless of how long the pixel clock holds them.
module control_pantalla_frame_sync
  import control_pantalla_pkg::*;
#(
  parameter logic [9:0] FRAME_LINE = FRAME_LINE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] qh,
  input  logic [9:0] qv,
  output logic       frame_tick
);

  logic cond;
  logic cond_q;

  assign cond = (qv == FRAME_LINE) && (qh == 10'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cond_q     <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      cond_q     <= cond;
      frame_tick <= cond && !cond_q;
    end
  end

endmodule

// File: rtl/control_pantalla.sv
// Display-mode controller: arbitrates edit/alarm requests, moves a blinking
// cursor over the 9 fields and publishes the decoded state once per frame.
module control_pantalla
  import control_pantalla_pkg::*;
#(
  parameter int unsigned BLINK_FRAMES         = 30,
  parameter int unsigned ALARM_TIMEOUT_FRAMES = 1800,
  parameter logic [9:0]  FRAME_LINE           = FRAME_LINE_DEF
) (
  input  logic       reloj,
  input  logic       resetM,
  input  logic [9:0] Qh,
  input  logic [9:0] Qv,
  input  logic       btn_hora,
  input  logic       btn_fecha,
  input  logic       btn_crono,
  input  logic       btn_der,
  input  logic       btn_izq,
  input  logic       btn_salir,
  input  logic       alarma_req,
  input  logic       alarma_ack,
  output logic       P_HORA,
  output logic       P_FECHA,
  output logic       P_CRONO,
  output logic [8:0] cam_co,
  output logic       bit_alarma,
  output logic       frame_tick
);

  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned AW = $clog2(ALARM_TIMEOUT_FRAMES + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_TIMEOUT_FRAMES);

  state_t        state, state_n;
  state_t        saved_state, saved_state_n;
  logic [1:0]    cursor, cursor_n;
  logic [1:0]    saved_cursor, saved_cursor_n;
  logic          phase, phase_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [AW-1:0] acnt, acnt_n;
  logic          req_q;

  logic          alarm_rise;
  logic          mode_btn;
  state_t        mode_tgt;
  logic          blink_run;

  control_pantalla_frame_sync #(
    .FRAME_LINE(FRAME_LINE)
  ) u_frame_sync (
    .clk       (reloj),
    .rst       (resetM),
    .qh        (Qh),
    .qv        (Qv),
    .frame_tick(frame_tick)
  );

  assign alarm_rise = alarma_req && !req_q;
  assign mode_btn   = btn_hora || btn_fecha || btn_crono;

  always_ff @(posedge reloj) begin
    if (resetM) begin
      state        <= NORMAL;
      saved_state  <= NORMAL;
      cursor       <= '0;
      saved_cursor <= '0;
      phase        <= 1'b1;
      bcnt         <= '0;
      acnt         <= '0;
      req_q        <= 1'b0;
    end else begin
      state        <= state_n;
      saved_state  <= saved_state_n;
      cursor       <= cursor_n;
      saved_cursor <= saved_cursor_n;
      phase        <= phase_n;
      bcnt         <= bcnt_n;
      acnt         <= acnt_n;
      req_q        <= alarma_req;
    end
  end

  always_comb begin
    state_n        = state;
    saved_state_n  = saved_state;
    cursor_n       = cursor;
    saved_cursor_n = saved_cursor;
    phase_n        = phase;
    bcnt_n         = bcnt;
    acnt_n         = acnt;
    blink_run      = is_edit(state);
    mode_tgt       = EDIT_CRONO;
    if (btn_hora) begin
      mode_tgt = EDIT_HORA;
    end else if (btn_fecha) begin
      mode_tgt = EDIT_FECHA;
    end

    if (alarm_rise) begin
      if (state != ALARMA) begin
        saved_state_n  = state;
        saved_cursor_n = cursor;
      end
      state_n   = ALARMA;
      acnt_n    = '0;
      bcnt_n    = '0;
      blink_run = 1'b0;
    end else if (state == ALARMA) begin
      blink_run = 1'b0;
      if (alarma_ack || (acnt == ALARM_LAST)) begin
        state_n  = saved_state;
        cursor_n = saved_cursor;
        acnt_n   = '0;
      end else if (frame_tick) begin
        acnt_n = acnt + 1'b1;
      end
    end else if (!alarma_ack) begin
      // A stray ack outside the alarm still consumes the cycle's lower events.
      if (btn_salir) begin
        if (is_edit(state)) begin
          state_n   = NORMAL;
          bcnt_n    = '0;
          blink_run = 1'b0;
        end
      end else if (mode_btn) begin
        if (mode_tgt != state) begin
          state_n   = mode_tgt;
          cursor_n  = '0;
          phase_n   = 1'b1;
          bcnt_n    = '0;
          blink_run = 1'b0;
        end
      end else if (is_edit(state) && (btn_der ^ btn_izq)) begin
        if (btn_der) begin
          cursor_n = (cursor == 2'd2) ? 2'd0 : cursor + 2'd1;
        end else begin
          cursor_n = (cursor == 2'd0) ? 2'd2 : cursor - 2'd1;
        end
        phase_n   = 1'b1;
        bcnt_n    = '0;
        blink_run = 1'b0;
      end
    end

    if (blink_run && frame_tick) begin
      if (bcnt == BLINK_LAST) begin
        bcnt_n  = '0;
        phase_n = !phase;
      end else begin
        bcnt_n = bcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge reloj) begin
    if (resetM) begin
      P_HORA     <= 1'b0;
      P_FECHA    <= 1'b0;
      P_CRONO    <= 1'b0;
      cam_co     <= '0;
      bit_alarma <= 1'b0;
    end else if (frame_tick) begin
      P_HORA     <= (state == EDIT_HORA);
      P_FECHA    <= (state == EDIT_FECHA);
      P_CRONO    <= (state == EDIT_CRONO);
      cam_co     <= phase ? field_mask(state, cursor) : '0;
      bit_alarma <= (state == ALARMA);
    end
  end

endmodule

// File: tb/tb_control_pantalla.sv
// Directed bench for control_pantalla with short blink/timeout parameters.
module tb_control_pantalla;

  logic       reloj = 1'b0;
  logic       resetM;
  logic [9:0] Qh, Qv;
  logic       btn_hora, btn_fecha, btn_crono, btn_der, btn_izq, btn_salir;
  logic       alarma_req, alarma_ack;
  logic       P_HORA, P_FECHA, P_CRONO, bit_alarma, frame_tick;
  logic [8:0] cam_co;

  int errors = 0;
  int checks = 0;
  int tick_cnt = 0;

  typedef struct {
    logic [5:0] btn;   // {hora, fecha, crono, der, izq, salir}
    logic       ack;
    logic       req;
    logic [2:0] p;     // {P_HORA, P_FECHA, P_CRONO}
    logic [8:0] cam;
    logic       alm;
  } vec_t;

  vec_t vt[29];
  logic [12:0] prev_exp;

  control_pantalla #(
    .BLINK_FRAMES(2),
    .ALARM_TIMEOUT_FRAMES(4),
    .FRAME_LINE(10'd515)
  ) dut (
    .reloj(reloj), .resetM(resetM), .Qh(Qh), .Qv(Qv),
    .btn_hora(btn_hora), .btn_fecha(btn_fecha), .btn_crono(btn_crono),
    .btn_der(btn_der), .btn_izq(btn_izq), .btn_salir(btn_salir),
    .alarma_req(alarma_req), .alarma_ack(alarma_ack),
    .P_HORA(P_HORA), .P_FECHA(P_FECHA), .P_CRONO(P_CRONO),
    .cam_co(cam_co), .bit_alarma(bit_alarma), .frame_tick(frame_tick)
  );

  always #5 reloj = ~reloj;

  always @(posedge reloj) begin
    if (frame_tick) tick_cnt <= tick_cnt + 1;
  end

  function automatic logic [12:0] outs();
    return {P_HORA, P_FECHA, P_CRONO, cam_co, bit_alarma};
  endfunction

  task automatic check(input string name, input int idx, input logic [12:0] got, input logic [12:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got=%b expected=%b", name, idx, got, exp);
    end
  endtask

  // Boundary condition held for 4 reloj cycles, then leave it.
  task automatic run_frame(input int idx);
    int t0;
    t0 = tick_cnt;
    @(negedge reloj);
    Qv = 10'd515; Qh = 10'd0;
    repeat (4) @(negedge reloj);
    Qv = 10'd100; Qh = 10'd37;
    repeat (4) @(negedge reloj);
    check("ticks_per_frame", idx, 13'(tick_cnt - t0), 13'd1);
  endtask

  task automatic step(input int i);
    @(negedge reloj);
    {btn_hora, btn_fecha, btn_crono, btn_der, btn_izq, btn_salir} = vt[i].btn;
    alarma_ack = vt[i].ack;
    alarma_req = vt[i].req;
    @(negedge reloj);
    {btn_hora, btn_fecha, btn_crono, btn_der, btn_izq, btn_salir} = '0;
    alarma_ack = 1'b0;
    repeat (2) @(negedge reloj);
    check("hold_until_tick", i, outs(), prev_exp);
    run_frame(i);
    prev_exp = {vt[i].p, vt[i].cam, vt[i].alm};
    check("after_tick", i, outs(), prev_exp);
  endtask

  initial begin
    vt[0]  = '{6'b100000, 1'b0, 1'b0, 3'b100, 9'b100000000, 1'b0};
    vt[1]  = '{6'b000000, 1'b0, 1'b0, 3'b100, 9'b100000000, 1'b0};
    vt[2]  = '{6'b000000, 1'b0, 1'b0, 3'b100, 9'b000000000, 1'b0};
    vt[3]  = '{6'b000000, 1'b0, 1'b0, 3'b100, 9'b000000000, 1'b0};
    vt[4]  = '{6'b000000, 1'b0, 1'b0, 3'b100, 9'b100000000, 1'b0};
    vt[5]  = '{6'b000000, 1'b0, 1'b0, 3'b100, 9'b100000000, 1'b0};
    vt[6]  = '{6'b010000, 1'b0, 1'b0, 3'b010, 9'b000100000, 1'b0};
    vt[7]  = '{6'b000010, 1'b0, 1'b0, 3'b010, 9'b000001000, 1'b0};
    vt[8]  = '{6'b000110, 1'b0, 1'b0, 3'b010, 9'b000001000, 1'b0};
    vt[9]  = '{6'b000100, 1'b0, 1'b0, 3'b010, 9'b000100000, 1'b0};
    vt[10] = '{6'b000100, 1'b0, 1'b0, 3'b010, 9'b000010000, 1'b0};
    vt[11] = '{6'b001000, 1'b0, 1'b0, 3'b001, 9'b000000100, 1'b0};
    vt[12] = '{6'b000100, 1'b0, 1'b0, 3'b001, 9'b000000010, 1'b0};
    vt[13] = '{6'b000000, 1'b0, 1'b1, 3'b000, 9'b000000000, 1'b1};
    vt[14] = '{6'b000000, 1'b1, 1'b1, 3'b001, 9'b000000010, 1'b0};
    vt[15] = '{6'b010000, 1'b0, 1'b1, 3'b010, 9'b000100000, 1'b0};
    vt[16] = '{6'b000000, 1'b0, 1'b0, 3'b010, 9'b000100000, 1'b0};
    vt[17] = '{6'b000000, 1'b0, 1'b1, 3'b000, 9'b000000000, 1'b1};
    vt[18] = '{6'b100000, 1'b0, 1'b1, 3'b000, 9'b000000000, 1'b1};
    vt[19] = '{6'b000000, 1'b0, 1'b1, 3'b000, 9'b000000000, 1'b1};
    vt[20] = '{6'b000000, 1'b0, 1'b1, 3'b000, 9'b000000000, 1'b1};
    vt[21] = '{6'b000000, 1'b0, 1'b1, 3'b010, 9'b000000000, 1'b0};
    vt[22] = '{6'b000000, 1'b0, 1'b1, 3'b010, 9'b000000000, 1'b0};
    vt[23] = '{6'b000000, 1'b0, 1'b1, 3'b010, 9'b000100000, 1'b0};
    vt[24] = '{6'b100000, 1'b0, 1'b1, 3'b100, 9'b100000000, 1'b0};
    vt[25] = '{6'b010001, 1'b0, 1'b1, 3'b000, 9'b000000000, 1'b0};
    vt[26] = '{6'b001000, 1'b0, 1'b1, 3'b001, 9'b000000100, 1'b0};
    vt[27] = '{6'b000100, 1'b0, 1'b1, 3'b001, 9'b000000010, 1'b0};
    vt[28] = '{6'b001000, 1'b0, 1'b1, 3'b001, 9'b000000010, 1'b0};

    resetM = 1'b1;
    Qv = 10'd100; Qh = 10'd37;
    {btn_hora, btn_fecha, btn_crono, btn_der, btn_izq, btn_salir} = '0;
    alarma_req = 1'b0; alarma_ack = 1'b0;
    repeat (3) @(negedge reloj);
    check("reset_outputs", 0, outs(), '0);
    check("reset_tick", 0, {12'd0, frame_tick}, '0);
    resetM = 1'b0;

    for (int f = 0; f < 3; f++) begin
      run_frame(f);
      check("idle_outputs", f, outs(), '0);
    end

    prev_exp = '0;
    for (int i = 0; i < 29; i++) begin
      step(i);
    end

    // Alarm raised, then reset mid-alarm clears everything at once.
    @(negedge reloj);
    alarma_req = 1'b0;
    @(negedge reloj);
    alarma_req = 1'b1;
    run_frame(100);
    check("alarm_before_reset", 0, outs(), 13'b000_000000000_1);
    @(negedge reloj);
    resetM = 1'b1;
    alarma_req = 1'b0;
    @(negedge reloj);
    check("reset_mid_alarm", 0, outs(), '0);
    resetM = 1'b0;
    run_frame(101);
    check("no_pending_after_reset", 0, outs(), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_pantalla.md
Name: control_pantalla

Overview:
Display-mode controller that drives the mode-select, field-highlight and alarm inputs of the RGB pixel colouring stage. It arbitrates user requests (time/date/stopwatch edit, cursor moves, exit) against alarm events and sequences a blinking edit cursor across the 9 on-screen fields. All visible outputs change only at a frame boundary, derived from the VGA counters, so no frame is drawn with mixed state.

Parameters:
BLINK_FRAMES, 30, frames per cursor blink half-period (cursor on for N frames, off for N frames)
ALARM_TIMEOUT_FRAMES, 1800, frames the alarm display stays up without ack before auto-exit
FRAME_LINE, 10'd515, Qv value at which the frame boundary is taken (inside vertical blank)

Ports:
reloj  in  1  system clock
resetM  in  1  synchronous reset, active-high
Qh  in  10  horizontal pixel counter from the sync generator
Qv  in  10  vertical line counter from the sync generator
btn_hora  in  1  one-cycle pulse (already debounced): request time-edit mode
btn_fecha  in  1  one-cycle pulse: request date-edit mode
btn_crono  in  1  one-cycle pulse: request stopwatch-edit mode
btn_der  in  1  one-cycle pulse: cursor right
btn_izq  in  1  one-cycle pulse: cursor left
btn_salir  in  1  one-cycle pulse: leave edit mode
alarma_req  in  1  level from timekeeper; rising edge raises the alarm
alarma_ack  in  1  one-cycle pulse: user acknowledges the alarm
P_HORA  out  1  time mode active (registered)
P_FECHA  out  1  date mode active (registered)
P_CRONO  out  1  stopwatch mode active (registered)
cam_co  out  9  one-hot field highlight; [8:6] time h/m/s, [5:3] date d/m/y, [2:0] stopwatch h/m/s
bit_alarma  out  1  alarm display active (registered)
frame_tick  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset: state NORMAL, cursor 0, saved state NORMAL, blink phase 1, blink/alarm counters 0; all outputs 0.
- frame_tick: registered; pulses for exactly one reloj cycle on the first cycle where (Qv==FRAME_LINE && Qh==0) becomes true after being false. It must not repeat while the condition holds, because reloj is faster than the pixel clock.
- States: NORMAL, EDIT_HORA, EDIT_FECHA, EDIT_CRONO, ALARMA. The state register updates every cycle. Outputs are loaded from the decoded state only on frame_tick. Worst-case visible latency is one frame plus 2 cycles.
- Per-cycle event priority, highest first:
  1. rising edge of alarma_req
  2. alarma_ack
  3. btn_salir
  4. btn_hora
  5. btn_fecha
  6. btn_crono
  7. cursor moves
  Lower-priority events in the same cycle are dropped.
- Alarm entry: from any non-ALARMA state, go to ALARMA.
  - Save the current state and cursor; clear the timeout counter.
  - A rising edge of alarma_req while already in ALARMA only restarts the timeout.
- ALARMA:
  - Decode: bit_alarma=1, P_*=0, cam_co=0.
  - The timeout counter increments on each frame_tick.
  - On alarma_ack, or when the counter reaches ALARM_TIMEOUT_FRAMES, restore the saved state and cursor.
  - btn_* inputs are ignored.
- NORMAL:
  - btn_hora, btn_fecha or btn_crono goes to the matching EDIT state with cursor 0 and blink phase 1.
  - Decode: all outputs 0.
- EDIT_x:
  - Decode: only the matching P_x is 1.
  - cam_co has the single bit (base - cursor) set when blink phase is 1, and is 0 when phase is 0. Base is 8, 5 or 2.
  - A mode button for the same mode does nothing.
  - A button for a different mode switches mode, resets cursor to 0 and sets blink phase to 1.
  - btn_salir goes to NORMAL.
- Cursor:
  - Range 0..2. btn_der increments, 2 wraps to 0. btn_izq decrements, 0 wraps to 2.
  - btn_der and btn_izq in the same cycle: no move.
  - Any move forces blink phase to 1 and clears the blink counter.
- Blink: in EDIT states the blink counter increments on frame_tick. At BLINK_FRAMES-1 it wraps to 0 and toggles the phase. It is held at 0 in NORMAL and ALARMA.
- Invariant: P_HORA, P_FECHA, P_CRONO are at most one-hot. Outside EDIT, cam_co is 0. bit_alarma=1 implies P_*=0.
- resetM asserted mid-frame or mid-alarm returns to reset values on the next edge, with no pending update retained.

Decomposition:
- Shared package:
  - state encoding constants (3-bit: NORMAL=0, EDIT_HORA=1, EDIT_FECHA=2, EDIT_CRONO=3, ALARMA=4)
  - cam_co field base constants (8, 5, 2)
  - default FRAME_LINE
- One sub-module, frame_sync: Qh/Qv compare plus edge detect producing frame_tick. The VGA side reuses it.

Test Plan (bench uses BLINK_FRAMES=2, ALARM_TIMEOUT_FRAMES=4):
- Reset, then run 3 frames: every output 0. frame_tick fires exactly once per frame even with Qh==0 held 4 cycles.
- btn_hora mid-frame: P_HORA stays 0 until the next frame_tick, then P_HORA=1, cam_co=9'b100000000. cam_co=0 for frames 3-4 and returns for frames 5-6.
- In EDIT_FECHA, btn_izq: after the next tick cam_co=9'b000001000 (wrap to year). btn_der and btn_izq in the same cycle: cursor unchanged.
- In EDIT_CRONO with cursor 1, raise alarma_req: next tick gives bit_alarma=1, P_*=0, cam_co=0. alarma_ack then restores P_CRONO=1, cam_co=9'b000000010 at the following tick.
- In ALARMA, no ack: bit_alarma drops to 0 after 4 frame_ticks. alarma_req held high does not re-trigger. btn_hora pressed during the alarm is ignored.
- btn_salir and btn_fecha in the same cycle while in EDIT_HORA: state goes to NORMAL (salir wins). resetM pulsed while in ALARMA: all outputs 0 on the next cycle.
